// File: rtl/mda_vram_arbiter.sv
// Arbitrates one single-port synchronous text RAM between display scanout, a host port and a
// screen-fill engine. Display has fixed priority and a fixed 3-cycle read latency.
module mda_vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 2000,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_starved,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_t;
    typedef enum logic {S_IDLE, S_FILL} fill_state_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    fill_state_t       fill_state;
    logic [ADDR_W-1:0] fill_ptr;
    logic [DATA_W-1:0] fill_value;
    tag_t              tag_ram;
    tag_t              tag_data;
    logic [CNT_W-1:0]  starve_cnt;
    logic              host_accept;
    logic              fill_grant;

    // Handshake: a host transfer happens in a cycle where host_valid and host_ready are both
    // high; the host must hold we/addr/wdata stable until then. Display simply pre-empts it.
    assign host_ready  = host_valid & ~disp_req;
    assign host_accept = host_ready;
    assign fill_grant  = (fill_state == S_FILL) & ~disp_req & ~host_valid;
    assign fill_busy   = (fill_state == S_FILL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            tag_ram   <= TAG_NONE;
        end else begin
            ram_en  <= disp_req | host_accept | fill_grant;
            ram_we  <= 1'b0;
            tag_ram <= TAG_NONE;
            if (disp_req) begin
                ram_addr <= disp_addr;
                tag_ram  <= TAG_DISP;
            end else if (host_accept) begin
                ram_addr  <= host_addr;
                ram_we    <= host_we;
                ram_wdata <= host_wdata;
                tag_ram   <= host_we ? TAG_NONE : TAG_HOST;
            end else if (fill_grant) begin
                ram_addr  <= fill_ptr;
                ram_we    <= 1'b1;
                ram_wdata <= fill_value;
            end
        end
    end

    // The owner tag follows the read one stage behind the RAM command, lining up with ram_rdata.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_data    <= TAG_NONE;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            tag_data    <= tag_ram;
            disp_rvalid <= (tag_data == TAG_DISP);
            host_rvalid <= (tag_data == TAG_HOST);
            if (tag_data == TAG_DISP) disp_rdata <= ram_rdata;
            if (tag_data == TAG_HOST) host_rdata <= ram_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_state <= S_IDLE;
            fill_ptr   <= '0;
            fill_value <= '0;
        end else begin
            case (fill_state)
                S_IDLE: begin
                    if (fill_start) begin
                        fill_state <= S_FILL;
                        fill_ptr   <= '0;
                        fill_value <= fill_data;
                    end
                end
                S_FILL: begin
                    if (fill_grant) begin
                        fill_ptr <= fill_ptr + ADDR_W'(1);
                        if (fill_ptr == ADDR_W'(DEPTH - 1)) fill_state <= S_IDLE;
                    end
                end
                default: fill_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt   <= '0;
            host_starved <= 1'b0;
        end else begin
            if (!host_valid || host_accept) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
                if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) host_starved <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// Directed bench for mda_vram_arbiter: a vector table for arbitration and read latency,
// plus hand-written fill, starvation and mid-flight reset sequences.
module tb_mda_vram_arbiter;

    logic        clock;
    logic        reset_n;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic        disp_rvalid;
    logic [15:0] disp_rdata;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [10:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_rvalid;
    logic [15:0] host_rdata;
    logic        host_starved;
    logic        fill_start;
    logic [15:0] fill_data;
    logic        fill_busy;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] mem [0:2047];

    mda_vram_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_starved(host_starved),
        .fill_start(fill_start), .fill_data(fill_data), .fill_busy(fill_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port RAM model; contents reload a known pattern while in reset.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'h073C + 16'(i);
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        d_req;
        logic [10:0] d_addr;
        logic        h_valid;
        logic        h_we;
        logic [10:0] h_addr;
        logic [15:0] h_wdata;
        logic        e_ready;
        logic        e_en;
        logic        e_we;
        logic [10:0] e_addr;
        logic        e_drv;
        logic [15:0] e_drd;
        logic        e_hrv;
        logic [15:0] e_hrd;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic dr, input logic [10:0] da, input logic hv,
                                input logic hw, input logic [10:0] ha, input logic [15:0] hd,
                                input logic er, input logic en, input logic we,
                                input logic [10:0] ea, input logic drv, input logic [15:0] drd,
                                input logic hrv, input logic [15:0] hrd);
        vec_t v;
        v.d_req = dr; v.d_addr = da; v.h_valid = hv; v.h_we = hw; v.h_addr = ha;
        v.h_wdata = hd; v.e_ready = er; v.e_en = en; v.e_we = we; v.e_addr = ea;
        v.e_drv = drv; v.e_drd = drd; v.e_hrv = hrv; v.e_hrd = hrd;
        return v;
    endfunction

    // Scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req = 0; disp_addr = 0; host_valid = 0; host_we = 0; host_addr = 0;
        host_wdata = 0; fill_start = 0; fill_data = 0;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 0;
        idle_inputs();
        @(negedge clock);
        tick();
        reset_n = 1;
    endtask

    task automatic disp_read(input logic [10:0] addr, input logic [15:0] exp, input string name);
        tick();
        disp_req = 1; disp_addr = addr;
        tick();
        disp_req = 0;
        tick();
        tick();
        @(negedge clock);
        check({name, "_rvalid"}, disp_rvalid, 1);
        check({name, "_rdata"}, disp_rdata, exp);
    endtask

    task automatic run_fill(input logic [15:0] data, input bit alt_disp, output int busy);
        tick();
        fill_start = 1; fill_data = data;
        @(negedge clock);
        tick();
        fill_start = 0; fill_data = 16'h1234; disp_req = alt_disp; disp_addr = 11'd9;
        busy = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clock);
            if (fill_busy) busy++;
            else break;
            tick();
            fill_start = (k == 1000);
            if (alt_disp) disp_req = ~disp_req;
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        int busy;
        int bad;
        bit saw;
        reset_n = 0;
        idle_inputs();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_disp_rvalid", disp_rvalid, 0);
        check("rst_disp_rdata", disp_rdata, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_host_starved", host_starved, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        tick();
        reset_n = 1;

        // Display read, host write pre-empted by display, host read burst.
        vecs[0]  = mk(1, 5, 0, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        vecs[1]  = mk(0, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 5, 0, 16'h0000, 0, 16'h0000);
        vecs[2]  = mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 0, 5, 0, 16'h0000, 0, 16'h0000);
        vecs[3]  = mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 0, 5, 1, 16'h0741, 0, 16'h0000);
        vecs[4]  = mk(1, 5, 1, 1, 5, 16'h0F41,  0, 0, 0, 5, 0, 16'h0741, 0, 16'h0000);
        vecs[5]  = mk(0, 0, 1, 1, 5, 16'h0F41,  1, 1, 0, 5, 0, 16'h0741, 0, 16'h0000);
        vecs[6]  = mk(1, 5, 0, 0, 0, 16'h0000,  0, 1, 1, 5, 0, 16'h0741, 0, 16'h0000);
        vecs[7]  = mk(0, 0, 1, 0, 0, 16'h0000,  1, 1, 0, 5, 1, 16'h0741, 0, 16'h0000);
        vecs[8]  = mk(0, 0, 1, 0, 1, 16'h0000,  1, 1, 0, 0, 0, 16'h0741, 0, 16'h0000);
        vecs[9]  = mk(0, 0, 1, 0, 2, 16'h0000,  1, 1, 0, 1, 1, 16'h0F41, 0, 16'h0000);
        vecs[10] = mk(0, 0, 1, 0, 3, 16'h0000,  1, 1, 0, 2, 0, 16'h0F41, 1, 16'h073C);
        vecs[11] = mk(0, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 3, 0, 16'h0F41, 1, 16'h073D);
        vecs[12] = mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 0, 3, 0, 16'h0F41, 1, 16'h073E);
        vecs[13] = mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 0, 3, 0, 16'h0F41, 1, 16'h073F);
        vecs[14] = mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 0, 3, 0, 16'h0F41, 0, 16'h073F);

        for (int i = 0; i < 15; i++) begin
            tick();
            disp_req = vecs[i].d_req; disp_addr = vecs[i].d_addr;
            host_valid = vecs[i].h_valid; host_we = vecs[i].h_we;
            host_addr = vecs[i].h_addr; host_wdata = vecs[i].h_wdata;
            @(negedge clock);
            check($sformatf("v%0d_host_ready", i), host_ready, vecs[i].e_ready);
            check($sformatf("v%0d_ram_en", i), ram_en, vecs[i].e_en);
            check($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
            check($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
            check($sformatf("v%0d_disp_rvalid", i), disp_rvalid, vecs[i].e_drv);
            check($sformatf("v%0d_disp_rdata", i), disp_rdata, vecs[i].e_drd);
            check($sformatf("v%0d_host_rvalid", i), host_rvalid, vecs[i].e_hrv);
            check($sformatf("v%0d_host_rdata", i), host_rdata, vecs[i].e_hrd);
        end
        check("host_wdata_in_ram", mem[5], 16'h0F41);

        // Fill with no other traffic; a second fill_start mid-fill must be ignored.
        run_fill(16'h0720, 1'b0, busy);
        check("fill_busy_cycles", busy, 2000);
        bad = 0;
        for (int i = 0; i < 2000; i++) if (mem[i] !== 16'h0720) bad++;
        check("fill_bad_cells", bad, 0);
        check("fill_beyond_depth", mem[2000], 16'h0F0C);
        disp_read(11'd1999, 16'h0720, "fill_last_cell");

        // Fill with display requests every other cycle.
        run_fill(16'h0F20, 1'b1, busy);
        check("fill_alt_busy_cycles", busy, 4000);
        check("fill_alt_cell0", mem[0], 16'h0F20);
        check("fill_alt_cell1999", mem[1999], 16'h0F20);

        // 63 denied cycles do not set starved.
        tick();
        disp_req = 1; host_valid = 1; host_we = 0; host_addr = 11'd2;
        for (int c = 1; c <= 63; c++) begin
            @(negedge clock);
            if (c == 63) check("starve_63_denied", host_starved, 0);
            tick();
        end
        disp_req = 0;
        @(negedge clock);
        check("starve_release_ready", host_ready, 1);
        check("starve_release_flag", host_starved, 0);
        tick();
        host_valid = 0;
        @(negedge clock);
        check("starve_after_clear", host_starved, 0);

        // 64 denied cycles set starved, which then sticks.
        tick();
        disp_req = 1; host_valid = 1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clock);
            if (c == 64) check("starve_during_64th", host_starved, 0);
            tick();
        end
        @(negedge clock);
        check("starve_after_64", host_starved, 1);
        tick();
        disp_req = 0;
        tick();
        host_valid = 0;
        repeat (3) tick();
        @(negedge clock);
        check("starve_sticky", host_starved, 1);
        do_reset();
        @(negedge clock);
        check("starve_reset_clears", host_starved, 0);

        // Reset between a read grant and its return, with a fill running.
        tick();
        fill_start = 1; fill_data = 16'h5555;
        tick();
        fill_start = 0;
        repeat (3) tick();
        @(negedge clock);
        check("midreset_fill_running", fill_busy, 1);
        tick();
        disp_req = 1; disp_addr = 11'd7;
        tick();
        disp_req = 0;
        reset_n = 0;
        @(negedge clock);
        check("midreset_fill_busy_now", fill_busy, 0);
        check("midreset_ram_en", ram_en, 0);
        tick();
        reset_n = 1;
        saw = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (disp_rvalid || host_rvalid) saw = 1;
            tick();
        end
        check("midreset_no_rvalid", saw, 0);
        check("midreset_fill_idle", fill_busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
